// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the imem req/ack handshake
// and hands fetched words to decode over a valid/ready pair.
module inst_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h3000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ack,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  input  logic        dec_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] currentPC,
  output logic        fetch_err
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [1:0]  state;
  logic        run;
  logic [15:0] flush_addr;
  logic [7:0]  wait_cnt;
  logic        req_live;
  logic        wait_hit;

  // run keeps the request low for the first cycle after reset release
  assign req_live  = run & (state != HOLD);
  assign imem_req  = req_live;
  assign imem_addr = (state == FLUSH) ? flush_addr : currentPC;
  assign wait_hit  = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= FETCH;
      run        <= 1'b0;
      currentPC  <= RESET_PC;
      flush_addr <= 16'h0000;
      inst_valid <= 1'b0;
      inst       <= 16'h0000;
      inst_pc    <= 16'h0000;
      fetch_err  <= 1'b0;
      wait_cnt   <= 8'd0;
    end else begin
      run       <= 1'b1;
      fetch_err <= 1'b0;
      if (redirect) begin
        currentPC  <= redirect_pc;
        inst_valid <= 1'b0;
        wait_cnt   <= 8'd0;
        unique case (state)
          FETCH: begin
            if (req_live && !imem_ack) begin
              state      <= FLUSH;
              flush_addr <= currentPC;
            end else begin
              state <= FETCH;
            end
          end
          HOLD:    state <= FETCH;
          FLUSH:   state <= imem_ack ? FETCH : FLUSH;
          default: state <= FETCH;
        endcase
      end else begin
        unique case (state)
          FETCH: begin
            if (req_live) begin
              if (imem_ack) begin
                inst       <= imem_rdata;
                inst_pc    <= currentPC;
                inst_valid <= 1'b1;
                currentPC  <= currentPC + 16'd1;
                state      <= HOLD;
                wait_cnt   <= 8'd0;
              end else if (wait_hit) begin
                fetch_err <= 1'b1;
                wait_cnt  <= 8'd0;
              end else begin
                wait_cnt <= wait_cnt + 8'd1;
              end
            end
          end
          HOLD: begin
            wait_cnt <= 8'd0;
            if (dec_ready) begin
              inst_valid <= 1'b0;
              state      <= FETCH;
            end
          end
          FLUSH: begin
            // data of the abandoned fetch is dropped on the floor
            if (imem_ack) begin
              state    <= FETCH;
              wait_cnt <= 8'd0;
            end else if (wait_hit) begin
              fetch_err <= 1'b1;
              wait_cnt  <= 8'd0;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
          default: begin
            state    <= FETCH;
            wait_cnt <= 8'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: handshake, hold, redirect/flush,
// timeout, PC wrap and mid-flight reset.
module tb_inst_fetch_unit;

  logic        clk;
  logic        reset;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic        dec_ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  logic        imem_req, imem_req2;
  logic [15:0] imem_addr, imem_addr2;
  logic        inst_valid, inst_valid2;
  logic [15:0] inst, inst2;
  logic [15:0] inst_pc, inst_pc2;
  logic [15:0] currentPC, currentPC2;
  logic        fetch_err, fetch_err2;

  int n_checks;
  int n_fail;

  inst_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .dec_ready(dec_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .currentPC(currentPC),
    .fetch_err(fetch_err)
  );

  inst_fetch_unit #(.RESET_PC(16'hFFFF), .MAX_WAIT(15)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2),
    .dec_ready(dec_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .currentPC(currentPC2),
    .fetch_err(fetch_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0;
    dec_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    step(); step();
    n_checks++;
    if ({imem_req, inst_valid, fetch_err, currentPC, inst, inst_pc} !==
        {1'b0, 1'b0, 1'b0, 16'h3000, 16'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_state: req=%b v=%b err=%b pc=%h inst=%h ipc=%h required 0 0 0 3000 0000 0000",
               imem_req, inst_valid, fetch_err, currentPC, inst, inst_pc);
    end
    reset = 1'b1;
    step();
    n_checks++;
    if ({imem_req, imem_addr, currentPC, inst_valid} !== {1'b1, 16'h3000, 16'h3000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release: req=%b addr=%h pc=%h v=%b required 1 3000 3000 0",
               imem_req, imem_addr, currentPC, inst_valid);
    end
  endtask

  task automatic test_fetch();
    dec_ready = 1'b1;
    step(); step();
    n_checks++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b1, 16'h3000, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_wait: req=%b addr=%h v=%b required 1 3000 0", imem_req, imem_addr, inst_valid);
    end
    imem_ack = 1'b1; imem_rdata = 16'h1234;
    step();
    imem_ack = 1'b0;
    n_checks++;
    if ({inst_valid, inst, inst_pc, currentPC, imem_req} !==
        {1'b1, 16'h1234, 16'h3000, 16'h3001, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_data: v=%b inst=%h ipc=%h pc=%h req=%b required 1 1234 3000 3001 0",
               inst_valid, inst, inst_pc, currentPC, imem_req);
    end
    step();
    n_checks++;
    if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h3001}) begin
      n_fail++;
      $display("FAIL fetch_next: v=%b req=%b addr=%h required 0 1 3001", inst_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_hold();
    int bad;
    dec_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h5678;
    step();
    imem_rdata = 16'hFFFF;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if ({inst_valid, inst, inst_pc, imem_req} !== {1'b1, 16'h5678, 16'h3001, 1'b0}) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_stable: %0d unstable cycles, inst=%h ipc=%h req=%b required 0 5678 3001 0",
               bad, inst, inst_pc, imem_req);
    end
    imem_ack = 1'b0; dec_ready = 1'b1;
    step();
    n_checks++;
    if ({inst_valid, imem_req, imem_addr, currentPC} !== {1'b0, 1'b1, 16'h3002, 16'h3002}) begin
      n_fail++;
      $display("FAIL hold_release: v=%b req=%b addr=%h pc=%h required 0 1 3002 3002",
               inst_valid, imem_req, imem_addr, currentPC);
    end
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 16'h4000;
    step();
    redirect = 1'b0;
    n_checks++;
    if ({imem_req, imem_addr, currentPC, inst_valid} !== {1'b1, 16'h3002, 16'h4000, 1'b0}) begin
      n_fail++;
      $display("FAIL redirect_flush: req=%b addr=%h pc=%h v=%b required 1 3002 4000 0",
               imem_req, imem_addr, currentPC, inst_valid);
    end
    step();
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    step();
    imem_ack = 1'b0;
    n_checks++;
    if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h4000}) begin
      n_fail++;
      $display("FAIL redirect_discard: v=%b req=%b addr=%h required 0 1 4000", inst_valid, imem_req, imem_addr);
    end
    dec_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h1111;
    step();
    imem_ack = 1'b0;
    n_checks++;
    if ({inst_valid, inst, inst_pc, currentPC} !== {1'b1, 16'h1111, 16'h4000, 16'h4001}) begin
      n_fail++;
      $display("FAIL redirect_target: v=%b inst=%h ipc=%h pc=%h required 1 1111 4000 4001",
               inst_valid, inst, inst_pc, currentPC);
    end
    redirect = 1'b1; redirect_pc = 16'h5000; dec_ready = 1'b1;
    step();
    redirect = 1'b0;
    n_checks++;
    if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h5000}) begin
      n_fail++;
      $display("FAIL redirect_hold: v=%b req=%b addr=%h required 0 1 5000", inst_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_back_to_back();
    imem_ack = 1'b1; imem_rdata = 16'hABCD; dec_ready = 1'b1;
    step();
    imem_ack = 1'b0;
    n_checks++;
    if ({inst_valid, inst, inst_pc} !== {1'b1, 16'hABCD, 16'h5000}) begin
      n_fail++;
      $display("FAIL b2b_first: v=%b inst=%h ipc=%h required 1 abcd 5000", inst_valid, inst, inst_pc);
    end
    step();
    imem_ack = 1'b1; imem_rdata = 16'h0102;
    step();
    imem_ack = 1'b0;
    n_checks++;
    if ({inst_valid, inst, inst_pc, currentPC} !== {1'b1, 16'h0102, 16'h5001, 16'h5002}) begin
      n_fail++;
      $display("FAIL b2b_second: v=%b inst=%h ipc=%h pc=%h required 1 0102 5001 5002",
               inst_valid, inst, inst_pc, currentPC);
    end
    step();
  endtask

  task automatic test_timeout();
    int pulses;
    int bad;
    pulses = 0; bad = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (fetch_err === 1'b1) pulses++;
      if ({imem_req, imem_addr} !== {1'b1, 16'h5002}) bad++;
      if (i == 15) begin
        n_checks++;
        if (pulses != 1) begin
          n_fail++;
          $display("FAIL timeout_15: pulses=%0d required 1", pulses);
        end
      end
    end
    n_checks++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL timeout_30: pulses=%0d required 2", pulses);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL timeout_req: %0d cycles with req/addr off, required 0", bad);
    end
  endtask

  task automatic test_wrap();
    reset = 1'b0;
    step(); step();
    n_checks++;
    if ({currentPC, currentPC2, imem_req2} !== {16'h3000, 16'hFFFF, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_reset: pc=%h pc2=%h req2=%b required 3000 ffff 0", currentPC, currentPC2, imem_req2);
    end
    reset = 1'b1;
    step();
    imem_ack = 1'b1; imem_rdata = 16'h0042; dec_ready = 1'b1;
    step();
    imem_ack = 1'b0;
    n_checks++;
    if ({inst_valid2, inst2, inst_pc2, currentPC2} !== {1'b1, 16'h0042, 16'hFFFF, 16'h0000}) begin
      n_fail++;
      $display("FAIL wrap_pc: v=%b inst=%h ipc=%h pc=%h required 1 0042 ffff 0000",
               inst_valid2, inst2, inst_pc2, currentPC2);
    end
  endtask

  task automatic test_reset_mid();
    step(); step(); step();
    reset = 1'b0;
    step();
    n_checks++;
    if ({imem_req, inst_valid, currentPC} !== {1'b0, 1'b0, 16'h3000}) begin
      n_fail++;
      $display("FAIL midreset_state: req=%b v=%b pc=%h required 0 0 3000", imem_req, inst_valid, currentPC);
    end
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    step();
    imem_ack = 1'b0;
    n_checks++;
    if ({imem_req, imem_addr, inst_valid, currentPC} !== {1'b1, 16'h3000, 1'b0, 16'h3000}) begin
      n_fail++;
      $display("FAIL midreset_late_ack: req=%b addr=%h v=%b pc=%h required 1 3000 0 3000",
               imem_req, imem_addr, inst_valid, currentPC);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_fetch();
    test_hold();
    test_redirect();
    test_back_to_back();
    test_timeout();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
